// File: rtl/mips_int_pkg.sv
// Shared constants for the MIPS interrupt request controller.
// Holds the source count, vector layout and FSM state encodings.
package mips_int_pkg;

  localparam int unsigned NUM_SRC    = 4;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE = 32'h0000_0010;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_REQ     = 2'b01;
  localparam logic [1:0] ST_SERVICE = 2'b10;

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-bit fixed-priority encoder.
// The lowest set index wins; valid flags a non-empty request set.
module prio_enc4 (
  input  logic [3:0] req,
  output logic       valid,
  output logic [1:0] id
);

  always_comb begin
    valid = |req;
    id    = 2'd0;
    unique casez (req)
      4'b???1: id = 2'd0;
      4'b??10: id = 2'd1;
      4'b?100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = 2'd0;
    endcase
  end

endmodule

// File: rtl/int_request_ctrl.sv
// Interrupt request controller: captures peripheral done edges,
// arbitrates by fixed priority and handshakes with the CPU.
module int_request_ctrl #(
  parameter int unsigned NUM_SRC    = mips_int_pkg::NUM_SRC,
  parameter logic [31:0] VEC_BASE   = mips_int_pkg::VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = mips_int_pkg::VEC_STRIDE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] done,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wd,
  input  logic               status_bit,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               interrupt,
  output logic [31:0]        int_addr,
  output logic [NUM_SRC-1:0] src_ack,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  import mips_int_pkg::*;

  logic [NUM_SRC-1:0] done_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [NUM_SRC-1:0] rise;
  logic [1:0]         state_q, state_d;
  logic [1:0]         gid_q, gid_d;
  logic [3:0]         elig;
  logic               ev;
  logic [1:0]         eid;

  assign elig = pend_q & mask_q;

  prio_enc4 u_enc (
    .req   (elig),
    .valid (ev),
    .id    (eid)
  );

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ack_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (status_bit && ev) begin
          state_d = ST_REQ;
          gid_d   = eid;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_d      = ST_SERVICE;
          ack_d[gid_q] = 1'b1;
        end else if (!status_bit) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // a fresh edge overrides the acknowledge clear of the same source
  assign rise   = done & ~done_q;
  assign pend_d = (pend_q & ~ack_d) | rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gid_q   <= 2'd0;
      done_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      done_q  <= done;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      if (mask_we) mask_q <= mask_wd;
    end
  end

  assign interrupt = (state_q == ST_REQ);
  assign busy      = (state_q == ST_SERVICE);
  assign src_ack   = ack_q;
  assign pending   = pend_q;
  assign int_addr  = interrupt ? VEC_BASE + VEC_STRIDE * {30'd0, gid_q}
                               : VEC_BASE;

endmodule

// File: tb/tb_int_request_ctrl.sv
// Self-checking bench for int_request_ctrl.
// Directed stimulus, a behavioural model and literal spot checks.
module tb_int_request_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  done = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wd = '0;
  logic        status_bit = 1'b1;
  logic        int_ack = 1'b0;
  logic        eoi = 1'b0;
  logic        interrupt;
  logic [31:0] int_addr;
  logic [3:0]  src_ack;
  logic [3:0]  pending;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  int_request_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .done       (done),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .status_bit (status_bit),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .interrupt  (interrupt),
    .int_addr   (int_addr),
    .src_ack    (src_ack),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: 0 waiting, 1 requesting the CPU, 2 being serviced
  int         m_phase;
  int         m_gid;
  logic [3:0] m_pend, m_prev, m_mask, m_ack, m_rise, m_clr, m_el;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_gid = 0; m_pend = '0; m_prev = '0;
      m_mask = 4'hF; m_ack = '0;
    end else begin
      m_rise = done & ~m_prev;
      m_prev = done;
      m_el   = m_pend & m_mask;
      m_clr  = '0;
      m_ack  = '0;
      if (m_phase == 0) begin
        if (status_bit && m_el != 0) begin
          for (int i = 3; i >= 0; i--) if (m_el[i]) m_gid = i;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (int_ack) begin
          m_ack[m_gid] = 1'b1;
          m_clr = m_ack;
          m_phase = 2;
        end else if (!status_bit) begin
          m_phase = 0;
        end
      end else if (eoi) begin
        m_phase = 0;
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
      if (mask_we) m_mask = mask_wd;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_interrupt", 32'(interrupt), 32'(m_phase == 1));
      chk("m_busy", 32'(busy), 32'(m_phase == 2));
      chk("m_src_ack", 32'(src_ack), 32'(m_ack));
      chk("m_pending", 32'(pending), 32'(m_pend));
      chk("m_int_addr", int_addr,
          (m_phase == 1) ? 32'h100 + 32'(m_gid) * 32'h10 : 32'h100);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_eoi();
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    chk("rst_addr", int_addr, 32'h100);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src_ack", 32'(src_ack), 32'd0);
    reset_n = 1'b1;
    model_on = 1'b1;
    cyc(2);

    // single request
    done = 4'b0100; cyc();
    chk("t1_pend", 32'(pending), 32'h4);
    chk("t1_int_early", 32'(interrupt), 32'd0);
    cyc();
    chk("t1_int", 32'(interrupt), 32'd1);
    chk("t1_addr", int_addr, 32'h120);
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    chk("t1_src_ack", 32'(src_ack), 32'h4);
    chk("t1_pend_clr", 32'(pending), 32'h0);
    chk("t1_busy", 32'(busy), 32'd1);
    cyc();
    chk("t1_src_ack_off", 32'(src_ack), 32'h0);
    eoi = 1'b1; cyc(); eoi = 1'b0;
    chk("t1_idle", 32'(busy), 32'd0);
    done = 4'b0000; cyc(2);

    // stray ack and eoi while idle
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);

    // priority
    done = 4'b1010; cyc(2);
    chk("t2_addr1", int_addr, 32'h110);
    ack_eoi();
    cyc();
    chk("t2_int2", 32'(interrupt), 32'd1);
    chk("t2_addr2", int_addr, 32'h130);
    ack_eoi();
    done = 4'b0000; cyc(2);

    // mask and global enable
    mask_we = 1'b1; mask_wd = 4'b1110; cyc(); mask_we = 1'b0;
    done = 4'b0001; cyc(3);
    chk("t3_pend", 32'(pending), 32'h1);
    chk("t3_noint", 32'(interrupt), 32'd0);
    mask_we = 1'b1; mask_wd = 4'hF; cyc(); mask_we = 1'b0;
    cyc();
    chk("t3_int", 32'(interrupt), 32'd1);
    chk("t3_addr", int_addr, 32'h100);
    status_bit = 1'b0; cyc();
    chk("t3_withdraw", 32'(interrupt), 32'd0);
    chk("t3_kept", 32'(pending), 32'h1);
    status_bit = 1'b1; cyc();
    ack_eoi();
    done = 4'b0000; cyc(2);

    // no nesting
    done = 4'b0100; cyc(2);
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    done = 4'b0101; cyc(2);
    chk("t4_noint", 32'(interrupt), 32'd0);
    chk("t4_pend", 32'(pending), 32'h1);
    eoi = 1'b1; cyc(); eoi = 1'b0;
    chk("t4_gap", 32'(interrupt), 32'd0);
    cyc();
    chk("t4_int", 32'(interrupt), 32'd1);
    chk("t4_addr", int_addr, 32'h100);
    ack_eoi();
    done = 4'b0000; cyc(2);

    // reset during REQ and during SERVICE
    done = 4'b0010; cyc(2);
    chk("t5_int", 32'(interrupt), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_int", 32'(interrupt), 32'd0);
    chk("t5_rst_pend", 32'(pending), 32'h0);
    chk("t5_rst_addr", int_addr, 32'h100);
    cyc(); reset_n = 1'b1; cyc();
    chk("t5_re_pend", 32'(pending), 32'h2);
    cyc();
    chk("t5_re_addr", int_addr, 32'h110);
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("t5_svc_busy", 32'(busy), 32'd0);
    chk("t5_svc_ack", 32'(src_ack), 32'h0);
    cyc(); reset_n = 1'b1; cyc(2);
    ack_eoi();
    done = 4'b0000; cyc(2);

    // same-cycle set and clear
    done = 4'b0100; cyc(2);
    done = 4'b0000; cyc();
    done = 4'b0100; int_ack = 1'b1; cyc(); int_ack = 1'b0;
    chk("t6_pend", 32'(pending), 32'h4);
    chk("t6_src_ack", 32'(src_ack), 32'h4);
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cyc();
    chk("t6_int", 32'(interrupt), 32'd1);
    chk("t6_addr", int_addr, 32'h120);
    ack_eoi();
    done = 4'b0000; cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
